// File: rtl/mlp_seq_pkg.sv
// Shared types and helpers for the MLP layer sequencer and its argmax scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mlp_seq_pkg;

  // Sequencer phases; 3-bit encoding leaves room for later states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    GAP    = 3'd2,
    SCAN   = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

  // Width of the layer index, sized for the 8-layer maximum.
  localparam int LAYER_IDX_W = 3;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Bundle of control, layer handshake, result-BRAM and report signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; layers answer with level done, BRAM has fixed 1-cycle read latency.
interface mlp_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DEPTH  = 10,
  parameter int CNT_W      = 32
);
  import mlp_seq_pkg::*;

  localparam int IDX_W = clog2_min1(OUT_DEPTH);

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        error;
  logic [LAYER_IDX_W-1:0]      err_layer;
  logic [NUM_LAYERS-1:0]       layer_start;
  logic [NUM_LAYERS-1:0]       layer_done;
  logic [IDX_W-1:0]            res_rdaddr;
  logic [DATA_WIDTH-1:0]       res_q;
  logic [IDX_W-1:0]            class_idx;
  logic [DATA_WIDTH-1:0]       class_score;
  logic                        class_valid;
  logic [CNT_W-1:0]            total_cycles;
  logic [NUM_LAYERS*CNT_W-1:0] perf_cycles;

  // Sequencer side.
  modport master (
    input  start, layer_done, res_q,
    output busy, done, error, err_layer, layer_start, res_rdaddr,
           class_idx, class_score, class_valid, total_cycles, perf_cycles
  );

  // Environment side: top-level control, layer instances and the result BRAM.
  modport slave (
    output start, layer_done, res_q,
    input  busy, done, error, err_layer, layer_start, res_rdaddr,
           class_idx, class_score, class_valid, total_cycles, perf_cycles
  );

endinterface

// File: rtl/mlp_argmax_scan.sv
// Walks the final-output BRAM once and keeps the signed maximum and its lowest index.
// Latency: go -> scan_done is OUT_DEPTH cycles (one address per cycle plus 1-cycle read).
// Backpressure: none; the scan runs to completion once go is pulsed.
module mlp_argmax_scan
  import mlp_seq_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int OUT_DEPTH  = 10,
  localparam int IDX_W      = clog2_min1(OUT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  output logic [IDX_W-1:0]      res_rdaddr,
  input  logic [DATA_WIDTH-1:0] res_q,
  output logic [IDX_W-1:0]      idx,
  output logic [DATA_WIDTH-1:0] score,
  output logic                  scan_done
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(OUT_DEPTH - 1);

  logic             addr_run;
  logic             cap_vld;
  logic             cap_first;
  logic             cap_last;
  logic [IDX_W-1:0] cap_idx;
  logic             issue;

  // Address 0 is already on the bus when go arrives, so go itself issues it.
  assign issue = go | addr_run;

  // Address generator; tags each read so the compare stage knows first/last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_rdaddr <= '0;
      addr_run   <= 1'b0;
      cap_vld    <= 1'b0;
      cap_first  <= 1'b0;
      cap_last   <= 1'b0;
      cap_idx    <= '0;
    end else begin
      cap_vld   <= issue;
      cap_first <= go;
      cap_idx   <= res_rdaddr;
      cap_last  <= (res_rdaddr == LAST_ADDR);
      if (issue) begin
        if (res_rdaddr == LAST_ADDR) begin
          res_rdaddr <= '0;
          addr_run   <= 1'b0;
        end else begin
          res_rdaddr <= res_rdaddr + IDX_W'(1);
          addr_run   <= 1'b1;
        end
      end
    end
  end

  // Compare/hold: first word seeds, later words win only when strictly greater.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      score <= '0;
    end else if (cap_vld && (cap_first || ($signed(res_q) > $signed(score)))) begin
      idx   <= cap_idx;
      score <= res_q;
    end
  end

  // Combinational so the sequencer leaves SCAN on the same edge the last word lands.
  assign scan_done = cap_vld & cap_last;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Runs NUM_LAYERS layers back to back with a 1-cycle gap, then scans results for argmax; optional per-layer perf counters under MLP_SEQ_PERF_EN.
// Latency: done pulses OUT_DEPTH+2 cycles after the last layer_done; per-layer watchdog of TIMEOUT_CYCLES.
// Backpressure: start is ignored while busy; layers hold off progress by keeping layer_done low.
module mlp_layer_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_DEPTH      = 10,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int CNT_W          = 32
) (
  input logic                   clk,
  input logic                   rst,
  mlp_layer_sequencer_if.master bus
);

  localparam logic [NUM_LAYERS-1:0]  START_ONE  = NUM_LAYERS'(1);
  localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]       TO_LAST    =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit                     TO_EN      = (TIMEOUT_CYCLES != 0);

  seq_state_t             state;
  logic [LAYER_IDX_W-1:0] idx;
  logic [CNT_W-1:0]       lcnt;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [LAYER_IDX_W-1:0] err_layer_q;
  logic [NUM_LAYERS-1:0]  layer_start_q;
  logic                   class_valid_q;
  logic [CNT_W-1:0]       total_q;
  logic                   scan_go;
  logic                   scan_done;
  logic                   act_done;

  // Only the done of the layer currently being started counts; others are noise.
  assign act_done = |(bus.layer_done & layer_start_q);

  // Sequencer FSM with all control outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      lcnt          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_layer_q   <= '0;
      layer_start_q <= '0;
      class_valid_q <= 1'b0;
      total_q       <= '0;
      scan_go       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      scan_go <= 1'b0;
      if (busy_q && (total_q != '1)) begin
        total_q <= total_q + CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            error_q       <= 1'b0;
            err_layer_q   <= '0;
            class_valid_q <= 1'b0;
            total_q       <= '0;
            idx           <= '0;
            lcnt          <= '0;
            layer_start_q <= START_ONE;
            busy_q        <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (act_done) begin
            layer_start_q <= '0;
            lcnt          <= '0;
            if (idx == LAST_LAYER) begin
              scan_go <= 1'b1;
              state   <= SCAN;
            end else begin
              state <= GAP;
            end
          end else if (TO_EN && (lcnt == TO_LAST)) begin
            layer_start_q <= '0;
            error_q       <= 1'b1;
            err_layer_q   <= idx;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else begin
            lcnt <= lcnt + CNT_ONE;
          end
        end
        GAP: begin
          idx           <= idx + LAYER_IDX_W'(1);
          layer_start_q <= START_ONE << (idx + LAYER_IDX_W'(1));
          state         <= RUN;
        end
        SCAN: begin
          if (scan_done) begin
            class_valid_q <= 1'b1;
            done_q        <= 1'b1;
            state         <= FINISH;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          layer_start_q <= '0;
          busy_q        <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  mlp_argmax_scan #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_DEPTH  (OUT_DEPTH)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .go         (scan_go),
    .res_rdaddr (bus.res_rdaddr),
    .res_q      (bus.res_q),
    .idx        (bus.class_idx),
    .score      (bus.class_score),
    .scan_done  (scan_done)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.err_layer    = err_layer_q;
  assign bus.layer_start  = layer_start_q;
  assign bus.class_valid  = class_valid_q;
  assign bus.total_cycles = total_q;

`ifdef MLP_SEQ_PERF_EN
  logic [CNT_W-1:0]            perf_q [NUM_LAYERS];
  logic [NUM_LAYERS*CNT_W-1:0] perf_flat;

  // Per-layer RUN-cycle counters; the one-hot start vector picks the live layer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) perf_q[i] <= '0;
    end else if ((state == IDLE) && bus.start) begin
      for (int i = 0; i < NUM_LAYERS; i++) perf_q[i] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (layer_start_q[i] && (perf_q[i] != '1)) perf_q[i] <= perf_q[i] + CNT_ONE;
      end
    end
  end

  // Flatten counters with layer 0 in the LSBs.
  always_comb begin
    perf_flat = '0;
    for (int i = 0; i < NUM_LAYERS; i++) perf_flat[i*CNT_W +: CNT_W] = perf_q[i];
  end

  assign bus.perf_cycles = perf_flat;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: layer BFMs, BRAM model and a trace-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mlp_layer_sequencer;
  localparam int NL = 3, DW = 16, OD = 10, TO = 20, CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.NUM_LAYERS(NL), .DATA_WIDTH(DW), .OUT_DEPTH(OD), .CNT_W(CW)) bus ();
  mlp_layer_sequencer #(.NUM_LAYERS(NL), .DATA_WIDTH(DW), .OUT_DEPTH(OD),
                        .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  mlp_layer_sequencer_if #(.NUM_LAYERS(NL), .DATA_WIDTH(DW), .OUT_DEPTH(1), .CNT_W(CW)) bus1 ();
  mlp_layer_sequencer #(.NUM_LAYERS(NL), .DATA_WIDTH(DW), .OUT_DEPTH(1),
                        .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment state: per-layer latency (0 = never finishes), BRAM contents, noise knobs.
  int            lat [NL];
  logic [DW-1:0] mem [OD];
  int            vals [OD];
  bit            spur2 = 1'b0;
  bit            noise = 1'b0;
  int            rc [NL];
  logic [3:0]    prev_addr = '0;

  // Layer BFMs (done in the lat-th cycle of start) and 1-cycle-latency BRAM.
  always @(negedge clk) begin
    logic [NL-1:0] ld;
    ld = '0;
    for (int i = 0; i < NL; i++) begin
      rc[i] = bus.layer_start[i] ? rc[i] + 1 : 0;
      if (bus.layer_start[i] && lat[i] != 0 && rc[i] == lat[i]) ld[i] = 1'b1;
    end
    if (spur2 && bus.layer_start[0]) ld[NL-1] = 1'b1;
    bus.layer_done = ld;
    bus.res_q      = mem[prev_addr];
    prev_addr      = bus.res_rdaddr;
  end

  int            rc1 [NL];
  logic [DW-1:0] m1 = '0;

  // Environment of the single-entry instance: every layer finishes after 2 cycles.
  always @(negedge clk) begin
    logic [NL-1:0] ld1;
    ld1 = '0;
    for (int i = 0; i < NL; i++) begin
      rc1[i] = bus1.layer_start[i] ? rc1[i] + 1 : 0;
      if (rc1[i] == 2) ld1[i] = 1'b1;
    end
    bus1.layer_done = ld1;
    bus1.res_q      = m1;
  end

  // Reference model: expected per-cycle layer_start trace from start to done.
  logic [NL-1:0]    exp_tr [$];
  int               exp_busy, exp_tl, exp_idx;
  bit               exp_to;
  logic [NL*CW-1:0] exp_perf;
  logic [DW-1:0]    exp_score;

  task automatic build_model();
    logic [NL-1:0] oh;
    exp_tr.delete();
    exp_perf = '0;
    exp_to   = 1'b0;
    exp_tl   = 0;
    for (int i = 0; i < NL && !exp_to; i++) begin
      int len;
      oh = '0;
      oh[i] = 1'b1;
      if (lat[i] == 0 || lat[i] > TO) begin
        len = TO; exp_to = 1'b1; exp_tl = i;
      end else begin
        len = lat[i];
      end
      repeat (len) exp_tr.push_back(oh);
`ifdef MLP_SEQ_PERF_EN
      exp_perf[i*CW +: CW] = CW'(len);
`endif
      if (!exp_to && i < NL - 1) exp_tr.push_back('0);
    end
    if (!exp_to) repeat (OD + 1) exp_tr.push_back('0);
    exp_tr.push_back('0);
    exp_busy  = exp_to ? exp_tr.size() - 1 : exp_tr.size();
    exp_idx   = 0;
    exp_score = mem[0];
    for (int j = 1; j < OD; j++) begin
      if ($signed(mem[j]) > $signed(exp_score)) begin
        exp_score = mem[j];
        exp_idx   = j;
      end
    end
  endtask

  task automatic run_case(input string nm);
    logic [NL-1:0] tr [$];
    int n, mism;
    bit seen;
    build_model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check({nm, "_err_clr"}, bus.error, 0);
    check({nm, "_cv_clr"}, bus.class_valid, 0);
    n = 0; seen = 1'b0;
    while (!seen && n < 1000) begin
      tr.push_back(bus.layer_start);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      n++;
    end
    bus.start = 1'b0;
    check({nm, "_done_seen"}, seen, 1);
    check({nm, "_trace_len"}, tr.size(), exp_tr.size());
    mism = 0;
    for (int k = 0; k < tr.size() && k < exp_tr.size(); k++) if (tr[k] !== exp_tr[k]) mism++;
    check({nm, "_trace_mism"}, mism, 0);
    check({nm, "_error"}, bus.error, exp_to);
    check({nm, "_class_valid"}, bus.class_valid, !exp_to);
    if (exp_to) begin
      check({nm, "_err_layer"}, bus.err_layer, exp_tl);
    end else begin
      check({nm, "_class_idx"}, bus.class_idx, exp_idx);
      check({nm, "_class_score"}, bus.class_score, exp_score);
    end
    @(negedge clk);
    check({nm, "_done_once"}, bus.done, 0);
    check({nm, "_idle"}, bus.busy, 0);
    check({nm, "_total"}, bus.total_cycles, exp_busy);
    check({nm, "_perf"}, bus.perf_cycles, exp_perf);
  endtask

  task automatic reset_mid(input string nm, input bit in_scan);
    int n, dn;
    bit hit;
    lat = '{5, 7, 3};
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      if (in_scan ? (bus.res_rdaddr == 4'd5) : bus.layer_start[1]) hit = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check({nm, "_reached"}, hit, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({nm, "_ctl"}, {bus.busy, bus.done, bus.error, bus.class_valid, bus.layer_start}, 0);
    check({nm, "_addr_idx"}, {bus.res_rdaddr, bus.class_idx, bus.err_layer}, 0);
    check({nm, "_score"}, bus.class_score, 0);
    check({nm, "_total"}, bus.total_cycles, 0);
    check({nm, "_perf"}, bus.perf_cycles, 0);
    dn = 0;
    repeat (30) begin @(negedge clk); dn += int'(bus.done); end
    check({nm, "_no_done"}, dn, 0);
  endtask

  initial begin
    int n, ldc, dc;
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    lat = '{5, 7, 3};
    for (int j = 0; j < OD; j++) mem[j] = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {bus.busy, bus.done, bus.error, bus.class_valid, bus.layer_start}, 0);
    check("rst_addr_idx", {bus.res_rdaddr, bus.class_idx, bus.err_layer}, 0);
    check("rst_score_total", {bus.class_score, bus.total_cycles}, 0);
    check("rst_perf", bus.perf_cycles, 0);
    check("rst_dut1", {bus1.busy, bus1.layer_start, bus1.class_valid}, 0);
    rst = 1'b0;

    // Nominal run: 5/7/3 latencies, max 9 first at index 2.
    vals = '{-3, 4, 9, 2, 9, 0, 1, -1, 5, 8};
    for (int j = 0; j < OD; j++) mem[j] = DW'(vals[j]);
    run_case("nominal");

    // Layer 1 never finishes.
    lat = '{5, 0, 3};
    run_case("timeout");

    // All-negative scores.
    lat = '{5, 7, 3};
    vals = '{-8, -2, -5, -7, -6, -3, -4, -9, -10, -9};
    for (int j = 0; j < OD; j++) mem[j] = DW'(vals[j]);
    run_case("allneg");

    // Stray start pulses and a spurious done from layer 2 while layer 0 runs.
    noise = 1'b1; spur2 = 1'b1;
    run_case("noise");
    noise = 1'b0; spur2 = 1'b0;

    // Done exactly at the watchdog limit wins over timeout.
    lat = '{20, 2, 20};
    run_case("edge_to");

    // Randomized runs, small value range to provoke ties.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, 22);
      for (int j = 0; j < OD; j++) mem[j] = DW'($urandom_range(0, 15)) - DW'(8);
      run_case($sformatf("rand%0d", r));
    end

    reset_mid("rst_scan", 1'b1);
    reset_mid("rst_run", 1'b0);
    lat = '{4, 6, 2};
    run_case("after_rst");

    // Single-entry result BRAM: done 3 cycles after the last layer_done.
    m1 = DW'($urandom_range(0, 65535));
    @(negedge clk); #1; bus1.start = 1'b1;
    @(negedge clk); #1; bus1.start = 1'b0;
    n = 0; ldc = -100; dc = -1;
    while (dc < 0 && n < 200) begin
      if (bus1.layer_start[NL-1] && bus1.layer_done[NL-1]) ldc = n;
      if (bus1.done) dc = n;
      else begin @(negedge clk); #1; end
      n++;
    end
    check("od1_latency", dc - ldc, 3);
    check("od1_idx", bus1.class_idx, 0);
    check("od1_score", bus1.class_score, m1);
    check("od1_valid", bus1.class_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
